diagonal_deskew: RTL and testbench

Receive-side realigner for the skewed diagonal stream leaving the systolic array's diagonal pipeline. Each 48-bit beat holds LANES lanes. In the skewed stream, lane k of a given row arrives k valid beats after lane 0 of that row. The block delays each lane so that all lanes of one row line up, then buffers the resulting rows in a small FIFO with a valid/ready output handshake toward the result writer.

---
 rtl/diagonal_deskew.sv | 154 +++++++++++++++
 tb/tb_diagonal_deskew.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diagonal_deskew.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | diagonal_deskew: realigns skewed diagonal lanes into rows, buffered in a |
// | small valid/ready FIFO.                            Revision: 1.0         |
// +--------------------------------------------------------------------------+
module diagonal_deskew #(
    parameter int LANES      = 3,
    parameter int LANE_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [47:0] input_diagonal,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] output_row,
    output logic        out_last,
    output logic        overflow,
    output logic        err_short
);

    localparam int c_cnt_w = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_occ_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_fill_done = c_cnt_w'(LANES - 1);
    localparam logic [c_occ_w-1:0] c_full_occ  = c_occ_w'(FIFO_DEPTH);

    logic [47:0]        w_row;
    logic               w_row_done;
    logic               w_short;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic [48:0]        w_head;

    logic [c_cnt_w-1:0] fill_cnt_q, fill_cnt_d;
    logic [c_ptr_w-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q,   rd_ptr_d;
    logic [c_occ_w-1:0] occ_q,      occ_d;
    logic               overflow_q, overflow_d;
    logic               err_short_q, err_short_d;
    logic [48:0]        mem_q [FIFO_DEPTH];
    logic [48:0]        mem_d [FIFO_DEPTH];

    // Lane k is held back LANES-1-k valid beats; the top lane bypasses the delay.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == LANES - 1) begin : g_direct
            assign w_row[k*LANE_W +: LANE_W] = input_diagonal[k*LANE_W +: LANE_W];
        end else begin : g_delay
            localparam int c_depth = LANES - 1 - k;
            logic [LANE_W-1:0] dly_q [c_depth];
            logic [LANE_W-1:0] dly_d [c_depth];

            always_comb begin
                for (int s = 0; s < c_depth; s++) begin
                    dly_d[s] = dly_q[s];
                end
                if (in_valid) begin
                    if (in_last) begin
                        for (int s = 0; s < c_depth; s++) begin
                            dly_d[s] = '0;
                        end
                    end else begin
                        dly_d[0] = input_diagonal[k*LANE_W +: LANE_W];
                        for (int s = 1; s < c_depth; s++) begin
                            dly_d[s] = dly_q[s-1];
                        end
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < c_depth; s++) begin
                        dly_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < c_depth; s++) begin
                        dly_q[s] <= dly_d[s];
                    end
                end
            end

            assign w_row[k*LANE_W +: LANE_W] = dly_q[c_depth-1];
        end
    end

    assign w_row_done = in_valid && (fill_cnt_q == c_fill_done);
    assign w_short    = in_valid && in_last && (fill_cnt_q != c_fill_done);
    assign w_pop      = (occ_q != '0) && out_ready;
    assign w_full     = (occ_q == c_full_occ);
    // A pop on the same edge frees the slot the new row needs.
    assign w_push     = w_row_done && (!w_full || w_pop);

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        if (in_valid) begin
            if (in_last) begin
                fill_cnt_d = '0;
            end else if (fill_cnt_q != c_fill_done) begin
                fill_cnt_d = fill_cnt_q + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (w_push) begin
            mem_d[wr_ptr_q] = {in_last, w_row};
        end
        wr_ptr_d    = wr_ptr_q + c_ptr_w'(w_push);
        rd_ptr_d    = rd_ptr_q + c_ptr_w'(w_pop);
        occ_d       = occ_q + c_occ_w'(w_push) - c_occ_w'(w_pop);
        overflow_d  = overflow_q | (w_row_done && w_full && !w_pop);
        err_short_d = err_short_q | w_short;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            overflow_q  <= 1'b0;
            err_short_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            overflow_q  <= overflow_d;
            err_short_q <= err_short_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign w_head     = mem_q[rd_ptr_q];
    assign out_valid  = (occ_q != '0);
    assign output_row = w_head[47:0];
    assign out_last   = w_head[48];
    assign overflow   = overflow_q;
    assign err_short  = err_short_q;

endmodule
`default_nettype wire

// File: tb/tb_diagonal_deskew.sv
`default_nettype none
// Directed bench for diagonal_deskew: framing, bubbles, backpressure,
// short matrices and asynchronous reset.
module tb_diagonal_deskew;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [47:0] input_diagonal;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] output_row;
    logic        out_last;
    logic        overflow;
    logic        err_short;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [48:0] got_q[$];
    int          got_cyc[$];

    diagonal_deskew #(
        .LANES(3),
        .LANE_W(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .input_diagonal(input_diagonal),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .output_row(output_row),
        .out_last(out_last),
        .overflow(overflow),
        .err_short(err_short)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every accepted head, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            got_q.push_back({out_last, output_row});
            got_cyc.push_back(cyc);
        end
    end

    // Skewed beat b of an n-row matrix: lane k carries row b-k, value {row, lane}.
    function automatic logic [47:0] mk_beat(input int b, input int n);
        logic [47:0] d;
        int r;
        d = '0;
        for (int k = 0; k < 3; k++) begin
            r = b - k;
            if (r >= 0 && r < n) d[k*16 +: 16] = {r[7:0], k[7:0]};
        end
        return d;
    endfunction

    function automatic logic [48:0] exp_row(input int r, input int n);
        return {(r == n - 1), 8'(r), 8'h02, 8'(r), 8'h01, 8'(r), 8'h00};
    endfunction

    // Drive one cycle of input; returns 1ns after the edge that sampled it.
    task automatic beat(input logic v, input logic [47:0] d, input logic l);
        in_valid       = v;
        input_diagonal = d;
        in_last        = l;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        input_diagonal = '0;
        in_last        = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; input_diagonal = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({out_valid, output_row, out_last, overflow, err_short} !== 52'h0) begin
            errors++;
            $display("FAIL reset_hold: got v=%b row=%h last=%b ovf=%b short=%b, expected all 0",
                     out_valid, output_row, out_last, overflow, err_short);
        end
        apply_reset();
        checks++;
        if ({out_valid, output_row, out_last, overflow, err_short} !== 52'h0) begin
            errors++;
            $display("FAIL reset_release: got v=%b row=%h last=%b ovf=%b short=%b, expected all 0",
                     out_valid, output_row, out_last, overflow, err_short);
        end
    endtask

    task automatic test_basic();
        int c_b2;
        c_b2 = 0;
        got_q.delete(); got_cyc.delete();
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            if (b == 2) c_b2 = cyc;
            beat(1'b1, mk_beat(b, 3), b == 4);
        end
        repeat (4) beat(1'b0, '0, 1'b0);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d rows, expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_row(i, 3)) begin
                errors++;
                $display("FAIL basic_row%0d: got %h, expected %h", i, got_q[i], exp_row(i, 3));
            end
            checks++;
            if (got_cyc[i] != c_b2 + 1 + i) begin
                errors++;
                $display("FAIL basic_time%0d: got cycle %0d, expected %0d", i, got_cyc[i], c_b2 + 1 + i);
            end
        end
        checks++;
        if ({out_valid, overflow, err_short} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got v=%b ovf=%b short=%b, expected 000", out_valid, overflow, err_short);
        end
    endtask

    task automatic test_bubbles();
        got_q.delete(); got_cyc.delete();
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            beat(1'b1, mk_beat(b, 3), b == 4);
            beat(1'b0, 48'hDEAD_BEEF_CAFE, 1'b1);
        end
        repeat (4) beat(1'b0, '0, 1'b0);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL bubble_count: got %0d rows, expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_row(i, 3)) begin
                errors++;
                $display("FAIL bubble_row%0d: got %h, expected %h", i, got_q[i], exp_row(i, 3));
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        out_ready = 1'b0;
        for (int b = 0; b < 10; b++) begin
            beat(1'b1, mk_beat(b, 8), b == 9);
            checks++;
            if (out_valid !== (b >= 2)) begin
                errors++;
                $display("FAIL ovf_valid_b%0d: got %b, expected %b", b, out_valid, (b >= 2));
            end
            checks++;
            if (overflow !== (b >= 6)) begin
                errors++;
                $display("FAIL ovf_flag_b%0d: got %b, expected %b", b, overflow, (b >= 6));
            end
        end
        repeat (2) beat(1'b0, '0, 1'b0);
        checks++;
        if (output_row !== exp_row(0, 8) || got_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_hold: got head %h with %0d pops, expected %h with 0",
                     output_row, got_q.size(), exp_row(0, 8));
        end
        out_ready = 1'b1;
        repeat (8) beat(1'b0, '0, 1'b0);
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d rows, expected 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_row(i, 8)) begin
                errors++;
                $display("FAIL ovf_drain_row%0d: got %h, expected %h", i, got_q[i], exp_row(i, 8));
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, expected 1", overflow);
        end
    endtask

    task automatic test_full_pop_push();
        apply_reset();
        out_ready = 1'b0;
        for (int b = 0; b < 7; b++) begin
            if (b == 6) begin
                checks++;
                if (!(out_valid === 1'b1 && dut.occ_q == 4 && overflow === 1'b0)) begin
                    errors++;
                    $display("FAIL fpp_full: got v=%b occ=%0d ovf=%b, expected 1/4/0", out_valid, dut.occ_q, overflow);
                end
                out_ready = 1'b1;
            end
            beat(1'b1, mk_beat(b, 5), b == 6);
        end
        repeat (6) beat(1'b0, '0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_overflow: got %b, expected 0", overflow);
        end
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL fpp_count: got %0d rows, expected 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_row(i, 5)) begin
                errors++;
                $display("FAIL fpp_row%0d: got %h, expected %h", i, got_q[i], exp_row(i, 5));
            end
        end
    endtask

    task automatic test_short();
        apply_reset();
        out_ready = 1'b1;
        beat(1'b1, mk_beat(0, 3), 1'b0);
        beat(1'b1, mk_beat(1, 3), 1'b1);
        repeat (3) beat(1'b0, '0, 1'b0);
        checks++;
        if (got_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_norow: got %0d rows v=%b, expected 0 rows v=0", got_q.size(), out_valid);
        end
        checks++;
        if (err_short !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL short_flag: got short=%b ovf=%b, expected 1/0", err_short, overflow);
        end
        for (int b = 0; b < 5; b++) beat(1'b1, mk_beat(b, 3), b == 4);
        repeat (4) beat(1'b0, '0, 1'b0);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL short_next_count: got %0d rows, expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_row(i, 3)) begin
                errors++;
                $display("FAIL short_next_row%0d: got %h, expected %h", i, got_q[i], exp_row(i, 3));
            end
        end
    endtask

    task automatic test_async_reset();
        got_q.delete(); got_cyc.delete();
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) beat(1'b1, mk_beat(b, 4), 1'b0);
        checks++;
        if (out_valid !== 1'b1 || output_row !== exp_row(0, 4)) begin
            errors++;
            $display("FAIL arst_pre: got v=%b row=%h, expected 1/%h", out_valid, output_row, exp_row(0, 4));
        end
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, output_row, out_last, overflow, err_short} !== 52'h0) begin
            errors++;
            $display("FAIL arst_immediate: got v=%b row=%h last=%b ovf=%b short=%b, expected all 0",
                     out_valid, output_row, out_last, overflow, err_short);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        got_q.delete(); got_cyc.delete();
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) beat(1'b1, mk_beat(b, 3), b == 4);
        repeat (4) beat(1'b0, '0, 1'b0);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL arst_count: got %0d rows, expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_row(i, 3)) begin
                errors++;
                $display("FAIL arst_row%0d: got %h, expected %h", i, got_q[i], exp_row(i, 3));
            end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        input_diagonal = '0;
        in_last        = 1'b0;
        out_ready      = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_overflow();
        test_full_pop_push();
        test_short();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
